// File: rtl/disp_page_sched.sv
// disp_page_sched: selects which four BCD digits (HH:MM, MM:SS or MM.DD) go to
// the display scan controller. Pages auto-rotate every DWELL seconds; a manual
// press advances immediately and suspends rotation for HOLD seconds.
module disp_page_sched #(
   parameter int unsigned DWELL = 5,   // auto-rotate seconds per page (1..15)
   parameter int unsigned HOLD  = 10   // seconds of manual hold after a press (1..15)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_next,
   input  logic       auto_en,
   input  logic [3:0] hr_tens,
   input  logic [3:0] hr_ones,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   input  logic [3:0] mon_tens,
   input  logic [3:0] mon_ones,
   input  logic [3:0] day_tens,
   input  logic [3:0] day_ones,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       dot,
   output logic [1:0] page,
   output logic       held
);

   typedef enum logic [1:0] {
      PG_HM   = 2'd0,
      PG_MS   = 2'd1,
      PG_DATE = 2'd2
   } page_t;

   typedef enum logic {
      M_AUTO = 1'b0,
      M_HOLD = 1'b1
   } mode_t;

   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
   localparam logic [3:0] HOLD_LAST  = 4'(HOLD - 1);

   page_t      page_q;
   page_t      page_nxt;
   mode_t      mode;
   logic [3:0] dwell_cnt;
   logic [3:0] hold_cnt;
   logic       armed;
   logic       tick_ok;
   logic       btn_ok;
   logic       auto_step;

   // Rotation order HM -> MS -> DATE -> HM; anything else falls back to HM.
   function automatic page_t next_page(input page_t p);
      case (p)
         PG_HM:   next_page = PG_MS;
         PG_MS:   next_page = PG_DATE;
         default: next_page = PG_HM;
      endcase
   endfunction

   // armed stays low for the first edge after reset release, so a tick or
   // press coincident with the release is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) armed <= 1'b0;
      else     armed <= 1'b1;
   end

   assign tick_ok   = tick_1hz & armed;
   assign btn_ok    = btn_next & armed;
   // A press in the same cycle takes priority, so auto_step only matters when
   // btn_ok is low; page_nxt still advances exactly one step either way.
   assign auto_step = (mode == M_AUTO) && auto_en && tick_ok && (dwell_cnt >= DWELL_LAST);

   // Next page: one step on a press or a dwell expiry, illegal code recovers to HM.
   always_comb begin
      // NOTE: default assignment first so no path through the block leaves
      // page_nxt unassigned, which would infer a latch.
      page_nxt = page_q;
      case (page_q)
         PG_HM, PG_MS, PG_DATE: begin
            if (btn_ok || auto_step) page_nxt = next_page(page_q);
         end
         default: page_nxt = PG_HM;
      endcase
   end

   // Page and mode state machine with its dwell and hold second counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         page_q    <= PG_HM;
         mode      <= M_AUTO;
         dwell_cnt <= 4'd0;
         hold_cnt  <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of the others, independent of statement order.
         page_q <= page_nxt;
         if (btn_ok) begin
            mode      <= M_HOLD;
            hold_cnt  <= 4'd0;
            dwell_cnt <= 4'd0;
         end else if (mode == M_HOLD) begin
            // Hold timeout runs regardless of auto_en.
            if (tick_ok) begin
               if (hold_cnt >= HOLD_LAST) begin
                  mode      <= M_AUTO;
                  hold_cnt  <= 4'd0;
                  dwell_cnt <= 4'd0;
               end else begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
         end else begin
            if (auto_step)               dwell_cnt <= 4'd0;
            else if (tick_ok && auto_en) dwell_cnt <= dwell_cnt + 4'd1;
         end
      end
   end

   // Decimal point: colon blink on HM, steady on MS/DATE, cleared on entering HM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dot <= 1'b0;
      end else if (page_nxt != PG_HM) begin
         dot <= 1'b1;
      end else if (page_q != PG_HM) begin
         dot <= 1'b0;
      end else if (tick_ok) begin
         dot <= ~dot;
      end
   end

   // Digit mux, registered from the current page and the live BCD inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit3 <= 4'd0;
         digit2 <= 4'd0;
         digit1 <= 4'd0;
         digit0 <= 4'd0;
      end else begin
         case (page_q)
            PG_HM: begin
               digit3 <= hr_tens;
               digit2 <= hr_ones;
               digit1 <= min_tens;
               digit0 <= min_ones;
            end
            PG_MS: begin
               digit3 <= min_tens;
               digit2 <= min_ones;
               digit1 <= sec_tens;
               digit0 <= sec_ones;
            end
            PG_DATE: begin
               digit3 <= mon_tens;
               digit2 <= mon_ones;
               digit1 <= day_tens;
               digit0 <= day_ones;
            end
            default: begin
               digit3 <= 4'd0;
               digit2 <= 4'd0;
               digit1 <= 4'd0;
               digit0 <= 4'd0;
            end
         endcase
      end
   end

   // page and held are straight flop outputs.
   assign page = page_q;
   assign held = (mode == M_HOLD);

endmodule

// File: tb/tb_disp_page_sched.sv
// tb_disp_page_sched: table-driven page/hold sequences checked through a
// scoreboard queue, followed by hand-written corner cases (collision, reset
// release, digit mapping and latency, reset during hold).
module tb_disp_page_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic       btn_next;
   logic       auto_en;
   logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
   logic [3:0] mon_tens, mon_ones, day_tens, day_ones;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       dot;
   logic [1:0] page;
   logic       held;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       t;
      logic       b;
      logic       a;
      logic [1:0] exp_page;
      logic       exp_held;
   } vec_t;

   typedef struct {
      string      name;
      logic [1:0] exp_page;
      logic       exp_held;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   disp_page_sched #(.DWELL(5), .HOLD(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_1hz (tick_1hz),
      .btn_next (btn_next),
      .auto_en  (auto_en),
      .hr_tens  (hr_tens),
      .hr_ones  (hr_ones),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .mon_tens (mon_tens),
      .mon_ones (mon_ones),
      .day_tens (day_tens),
      .day_ones (day_ones),
      .digit3   (digit3),
      .digit2   (digit2),
      .digit1   (digit1),
      .digit0   (digit0),
      .dot      (dot),
      .page     (page),
      .held     (held)
   );

   always #50 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic t, input logic b, input logic a,
                      input logic [1:0] p, input logic h);
      vec_t v;
      v.t = t; v.b = b; v.a = a; v.exp_page = p; v.exp_held = h;
      vecs.push_back(v);
   endtask

   // One stimulus cycle: expectation queued when driven, popped after the edge.
   task automatic drive(input string name, input logic t, input logic b, input logic a,
                        input logic [1:0] p, input logic h);
      exp_t e;
      e.name = name; e.exp_page = p; e.exp_held = h;
      sb.push_back(e);
      @(negedge clk);
      tick_1hz = t;
      btn_next = b;
      auto_en  = a;
      @(negedge clk);
      tick_1hz = 1'b0;
      btn_next = 1'b0;
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.name, "_page"}, 32'(page), 32'(e.exp_page));
         check({e.name, "_held"}, 32'(held), 32'(e.exp_held));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      tick_1hz = 1'b0;
      btn_next = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [15:0] digits();
      return {digit3, digit2, digit1, digit0};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      tick_1hz = 1'b0;
      btn_next = 1'b0;
      auto_en  = 1'b1;
      {hr_tens, hr_ones, min_tens, min_ones} = 16'h1234;
      {sec_tens, sec_ones}                   = 8'h56;
      {mon_tens, mon_ones, day_tens, day_ones} = 16'h0413;

      // Auto-rotate: 15 ticks, advance on ticks 5, 10, 15.
      for (int i = 1; i <= 15; i++) add(1'b1, 1'b0, 1'b1, 2'((i / 5) % 3), 1'b0);
      // Manual hold: press, 9 held ticks, release on tick 10, advance 5 ticks later.
      add(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      for (int i = 1; i <= 9; i++) add(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
      add(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
      for (int i = 1; i <= 4; i++) add(1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
      add(1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
      // Back to HM, then auto_en=0 for 20 ticks, then a press still works.
      for (int i = 1; i <= 4; i++) add(1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
      add(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      for (int i = 1; i <= 20; i++) add(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 2'd1, 1'b1);

      // Reset state, asserted asynchronously before any clock edge.
      #10 rst = 1'b1;
      #10;
      check("rst_page",   32'(page),     32'd0);
      check("rst_held",   32'(held),     32'd0);
      check("rst_digits", 32'(digits()), 32'd0);
      check("rst_dot",    32'(dot),      32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive($sformatf("vec%0d", i), vecs[i].t, vecs[i].b, vecs[i].a,
               vecs[i].exp_page, vecs[i].exp_held);
      end
      check("sb_drained", 32'(sb.size()), 32'd0);

      // Collision: press with the 5th tick on HM moves one page only.
      do_reset();
      for (int i = 1; i <= 4; i++) drive($sformatf("col_t%0d", i), 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      drive("col_hit", 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
      check("col_dwell", 32'(dut.dwell_cnt), 32'd0);

      // Tick and press coincident with reset release are ignored.
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      tick_1hz = 1'b1;
      btn_next = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      btn_next = 1'b0;
      check("rel_page",  32'(page),          32'd0);
      check("rel_held",  32'(held),          32'd0);
      check("rel_dwell", 32'(dut.dwell_cnt), 32'd0);
      for (int i = 1; i <= 4; i++) drive($sformatf("rel_t%0d", i), 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      drive("rel_t5", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);

      // Digit mapping, latency and dot behaviour.
      do_reset();
      @(negedge clk);
      check("map_hm",   32'(digits()), 32'h1234);
      check("map_dot0", 32'(dot),      32'd0);
      drive("blink1", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      check("map_dot1", 32'(dot), 32'd1);
      drive("blink2", 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      check("map_dot2", 32'(dot), 32'd0);
      min_ones = 4'd9;
      @(negedge clk);
      check("map_in_lat", 32'(digits()), 32'h1239);
      min_ones = 4'd4;
      drive("to_ms", 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      check("ms_lat",  32'(digits()), 32'h1234);
      check("ms_dot",  32'(dot),      32'd1);
      @(negedge clk);
      check("map_ms",  32'(digits()), 32'h3456);
      drive("to_date", 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
      check("date_lat", 32'(digits()), 32'h3456);
      @(negedge clk);
      check("map_date", 32'(digits()), 32'h0413);
      check("date_dot", 32'(dot),      32'd1);
      drive("to_hm", 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
      check("hm_dot_entry", 32'(dot), 32'd0);
      @(negedge clk);
      check("map_hm2", 32'(digits()), 32'h1234);

      // Reset mid-hold: outputs clear at once, fresh dwell afterwards.
      drive("mh_btn", 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
      for (int i = 1; i <= 3; i++) drive($sformatf("mh_t%0d", i), 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
      @(negedge clk);
      #10 rst = 1'b1;
      #1;
      check("mh_page",   32'(page),         32'd0);
      check("mh_held",   32'(held),         32'd0);
      check("mh_digits", 32'(digits()),     32'd0);
      check("mh_dot",    32'(dot),          32'd0);
      check("mh_hold",   32'(dut.hold_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) drive($sformatf("mh_a%0d", i), 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
      drive("mh_a5", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
